// File: rtl/alu_sequencer_if.sv
// Handshake and adder bus between the sequencer, its requester, the adder unit and the register file.
interface alu_sequencer_if;
    logic       start;
    logic [7:0] instr;
    logic [7:0] b_in;
    logic [7:0] c_in;
    logic [7:0] adder_sum;
    logic       adder_carry;
    logic [7:0] adder_b;
    logic [7:0] adder_c;
    logic [7:0] result;
    logic       we_a;
    logic       we_d;
    logic       flag_sign;
    logic       flag_zero;
    logic       flag_carry;
    logic       busy;
    logic       done;
    logic       illegal;

    // Requester side: issues instructions and hosts the adder unit.
    modport master (
        output start, instr, b_in, c_in, adder_sum, adder_carry,
        input  adder_b, adder_c, result, we_a, we_d,
               flag_sign, flag_zero, flag_carry, busy, done, illegal
    );

    // Sequencer side.
    modport slave (
        input  start, instr, b_in, c_in, adder_sum, adder_carry,
        output adder_b, adder_c, result, we_a, we_d,
               flag_sign, flag_zero, flag_carry, busy, done, illegal
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU controller: decode 1000 r fff, hold operands on the shared
// adder for a settle interval, then latch result/flags and strobe A or D.
module alu_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    alu_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SELECT, SETTLE, LATCH} state_t;

    localparam logic [2:0] FN_ADD = 3'd0;
    localparam logic [2:0] FN_INC = 3'd1;
    localparam logic [2:0] FN_AND = 3'd2;
    localparam logic [2:0] FN_OR  = 3'd3;
    localparam logic [2:0] FN_XOR = 3'd4;
    localparam logic [2:0] FN_NOT = 3'd5;
    localparam logic [2:0] FN_SHL = 3'd6;
    localparam logic [2:0] FN_CLR = 3'd7;

    state_t           state_q,   state_nxt;
    logic [CNT_W-1:0] cnt_q,     cnt_nxt;
    logic [7:0]       b_q,       b_nxt;
    logic [7:0]       c_q,       c_nxt;
    logic [7:0]       adc_q,     adc_nxt;
    logic [2:0]       fn_q,      fn_nxt;
    logic             dest_q,    dest_nxt;
    logic [7:0]       result_q,  result_nxt;
    logic             sign_q,    sign_nxt;
    logic             zero_q,    zero_nxt;
    logic             carry_q,   carry_nxt;
    logic             we_a_q,    we_a_nxt;
    logic             we_d_q,    we_d_nxt;
    logic             busy_q,    busy_nxt;
    logic             done_q,    done_nxt;
    logic             illegal_q, illegal_nxt;
    logic [7:0]       res_c;
    logic             cry_c;

    // Function unit: arithmetic comes from the adder, the rest is local logic.
    always_comb begin
        res_c = 8'h00;
        cry_c = 1'b0;
        case (fn_q)
            FN_ADD, FN_INC: begin
                res_c = bus.adder_sum;
                cry_c = bus.adder_carry;
            end
            FN_AND: res_c = b_q & c_q;
            FN_OR:  res_c = b_q | c_q;
            FN_XOR: res_c = b_q ^ c_q;
            FN_NOT: res_c = ~b_q;
            FN_SHL: res_c = {b_q[6:0], b_q[7]};
            FN_CLR: res_c = 8'h00;
            default: res_c = 8'h00;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        b_nxt       = b_q;
        c_nxt       = c_q;
        adc_nxt     = adc_q;
        fn_nxt      = fn_q;
        dest_nxt    = dest_q;
        result_nxt  = result_q;
        sign_nxt    = sign_q;
        zero_nxt    = zero_q;
        carry_nxt   = carry_q;
        busy_nxt    = busy_q;
        we_a_nxt    = 1'b0;
        we_d_nxt    = 1'b0;
        done_nxt    = 1'b0;
        illegal_nxt = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.instr[7:4] == 4'b1000) begin
                        b_nxt     = bus.b_in;
                        c_nxt     = bus.c_in;
                        adc_nxt   = (bus.instr[2:0] == FN_INC) ? 8'h01 : bus.c_in;
                        fn_nxt    = bus.instr[2:0];
                        dest_nxt  = bus.instr[3];
                        busy_nxt  = 1'b1;
                        state_nxt = SELECT;
                    end else begin
                        illegal_nxt = 1'b1;
                    end
                end
            end
            SELECT: begin
                cnt_nxt   = CNT_W'(SETTLE_CYCLES);
                state_nxt = SETTLE;
            end
            SETTLE: begin
                cnt_nxt = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                result_nxt = res_c;
                carry_nxt  = cry_c;
                zero_nxt   = (res_c == 8'h00);
                sign_nxt   = res_c[7];
                we_a_nxt   = ~dest_q;
                we_d_nxt   = dest_q;
                done_nxt   = 1'b1;
                busy_nxt   = 1'b0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            b_q       <= 8'h00;
            c_q       <= 8'h00;
            adc_q     <= 8'h00;
            fn_q      <= 3'd0;
            dest_q    <= 1'b0;
            result_q  <= 8'h00;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            we_a_q    <= 1'b0;
            we_d_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            b_q       <= b_nxt;
            c_q       <= c_nxt;
            adc_q     <= adc_nxt;
            fn_q      <= fn_nxt;
            dest_q    <= dest_nxt;
            result_q  <= result_nxt;
            sign_q    <= sign_nxt;
            zero_q    <= zero_nxt;
            carry_q   <= carry_nxt;
            we_a_q    <= we_a_nxt;
            we_d_q    <= we_d_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            illegal_q <= illegal_nxt;
        end
    end

    assign bus.adder_b    = b_q;
    assign bus.adder_c    = adc_q;
    assign bus.result     = result_q;
    assign bus.flag_sign  = sign_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_carry = carry_q;
    assign bus.we_a       = we_a_q;
    assign bus.we_d       = we_d_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.illegal    = illegal_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed scoreboard bench for alu_sequencer with a behavioural adder unit.
module tb_alu_sequencer;
    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       s;
        logic       wa;
        logic       wd;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t last;
    logic [7:0] exp_ab;
    logic [7:0] exp_ac;

    alu_sequencer_if bus ();

    alu_sequencer #(.SETTLE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Adder unit model
    assign {bus.adder_carry, bus.adder_sum} = {1'b0, bus.adder_b} + {1'b0, bus.adder_c};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] ins, input logic [7:0] b, input logic [7:0] c);
        exp_t e;
        logic [8:0] w;
        e = '0;
        w = 9'h000;
        case (ins[2:0])
            3'd0: w = {1'b0, b} + {1'b0, c};
            3'd1: w = {1'b0, b} + 9'h001;
            3'd2: w = {1'b0, b & c};
            3'd3: w = {1'b0, b | c};
            3'd4: w = {1'b0, b ^ c};
            3'd5: w = {1'b0, ~b};
            3'd6: w = {1'b0, b[6:0], b[7]};
            default: w = 9'h000;
        endcase
        e.res = w[7:0];
        e.c   = w[8];
        e.z   = (w[7:0] == 8'h00);
        e.s   = w[7];
        e.wa  = ~ins[3];
        e.wd  = ins[3];
        return e;
    endfunction

    // Drive a start for one edge; returns in cycle T+1 with garbage on the inputs.
    task automatic launch(input logic [7:0] ins, input logic [7:0] b, input logic [7:0] c);
        bus.start = 1'b1;
        bus.instr = ins;
        bus.b_in  = b;
        bus.c_in  = c;
        sb.push_back(model(ins, b, c));
        exp_ab = b;
        exp_ac = (ins[2:0] == 3'd1) ? 8'h01 : c;
        step();
        bus.start = 1'b0;
        bus.instr = 8'($urandom);
        bus.b_in  = 8'($urandom);
        bus.c_in  = 8'($urandom);
    endtask

    // Track the op to its done cycle; optionally pulse a stray start at cycle T+inj.
    task automatic finish_op(input int inj);
        int   lat;
        exp_t e;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            check("busy", 32'(bus.busy), 1);
            check("adder_b", 32'(bus.adder_b), 32'(exp_ab));
            check("adder_c", 32'(bus.adder_c), 32'(exp_ac));
            check("we_early", 32'({bus.we_a, bus.we_d}), 0);
            if (lat == inj) begin
                bus.start = 1'b1;
                bus.instr = 8'h87;
            end else begin
                bus.start = 1'b0;
            end
            step();
            lat++;
        end
        bus.start = 1'b0;
        check("latency", 32'(lat), 7);
        check("busy_done", 32'(bus.busy), 0);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("result", 32'(bus.result), 32'(e.res));
            check("carry", 32'(bus.flag_carry), 32'(e.c));
            check("zero", 32'(bus.flag_zero), 32'(e.z));
            check("sign", 32'(bus.flag_sign), 32'(e.s));
            check("we_a", 32'(bus.we_a), 32'(e.wa));
            check("we_d", 32'(bus.we_d), 32'(e.wd));
            last = e;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, 32'({bus.result, bus.adder_b, bus.adder_c}), 0);
        check({tag, "_ctl"}, 32'({bus.we_a, bus.we_d, bus.flag_sign, bus.flag_zero,
                                  bus.flag_carry, bus.busy, bus.done, bus.illegal}), 0);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.instr = 8'h00;
        bus.b_in  = 8'h00;
        bus.c_in  = 8'h00;
        last      = '0;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // ADD to A, then ADD to D with wraparound carry
        launch(8'h80, 8'h00, 8'h01);
        finish_op(0);
        step();
        check("done_pulse", 32'(bus.done), 0);
        check("we_pulse", 32'({bus.we_a, bus.we_d}), 0);
        check("result_hold", 32'(bus.result), 32'(last.res));
        launch(8'h88, 8'hFF, 8'h01);
        finish_op(0);
        step();

        // INC and circular shift
        launch(8'h81, 8'h7F, 8'h55);
        finish_op(0);
        step();
        launch(8'h86, 8'h81, 8'h00);
        finish_op(0);
        step();

        // Logic ops, INC overflow, clear
        launch(8'h82, 8'hF0, 8'h3C); finish_op(0); step();
        launch(8'h8B, 8'hA0, 8'h05); finish_op(0); step();
        launch(8'h84, 8'hFF, 8'hFF); finish_op(0); step();
        launch(8'h8D, 8'h5A, 8'h00); finish_op(0); step();
        launch(8'h89, 8'hFF, 8'h10); finish_op(0); step();
        launch(8'h87, 8'h12, 8'h34); finish_op(0); step();

        // Stray start while busy, then back-to-back start in the done cycle
        launch(8'h80, 8'h40, 8'h41);
        finish_op(3);
        launch(8'h8C, 8'h0F, 8'hF0);
        finish_op(0);
        step();
        check("b2b_done_pulse", 32'(bus.done), 0);

        // Non-ALU instruction
        bus.start = 1'b1;
        bus.instr = 8'h90;
        step();
        bus.start = 1'b0;
        check("illegal", 32'(bus.illegal), 1);
        check("illegal_busy", 32'(bus.busy), 0);
        check("illegal_we", 32'({bus.we_a, bus.we_d, bus.done}), 0);
        check("illegal_result", 32'(bus.result), 32'(last.res));
        check("illegal_flags", 32'({bus.flag_sign, bus.flag_zero, bus.flag_carry}),
              32'({last.s, last.z, last.c}));
        step();
        check("illegal_pulse", 32'(bus.illegal), 0);
        check("illegal_idle", 32'(bus.busy), 0);

        // Reset during settle aborts the op
        launch(8'h80, 8'h12, 8'h34);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        if (sb.size() > 0) sb.delete(sb.size() - 1);
        check_all_zero("abort");
        for (int i = 0; i < 8; i++) begin
            check("abort_quiet", 32'({bus.done, bus.we_a, bus.we_d, bus.busy}), 0);
            step();
        end
        launch(8'h88, 8'h80, 8'h80);
        finish_op(0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller for the 8-bit ALU built around the shared combinational EightBitAdderUnit.
- Decodes an ALU instruction of the form 1000 r fff and captures the B/C register operands.
- Drives the adder inputs, waits a relay-style settle interval, then latches the result plus sign/zero/carry flags and issues a one-cycle write enable to destination register A or D.
- Sits between the instruction decoder/sequencer and the register file.

Parameters:
SETTLE_CYCLES, 4, number of cycles operands are held on the adder before result is sampled (min 1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
instr  in  8  instruction byte; valid with start
b_in  in  8  register B value; captured with start
c_in  in  8  register C value; captured with start
adder_sum  in  8  sum from adder unit
adder_carry  in  1  carry-out from adder unit
adder_b  out  8  operand 1 to adder unit
adder_c  out  8  operand 2 to adder unit
result  out  8  latched ALU result
we_a  out  1  one-cycle write strobe, destination A
we_d  out  1  one-cycle write strobe, destination D
flag_sign  out  1  result[7] of last completed op
flag_zero  out  1  result == 0 of last completed op
flag_carry  out  1  carry of last completed op
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
illegal  out  1  one-cycle pulse; start with non-ALU instr

Behaviour:
- Reset values: every output is 0, state IDLE, operand registers 0, settle counter 0.
- Reset dominates any state, including mid-settle. No write strobe or done is produced for an aborted op, and flags clear to 0.
- Decode: instr[7:4] must equal 4'b1000.
  - r = instr[3]: 0 selects A, 1 selects D.
  - fff = instr[2:0].
- States: IDLE -> SELECT -> SETTLE -> LATCH -> IDLE.
- IDLE, start=1, legal instr (edge T): capture b_in, c_in, r and fff; go to SELECT.
- IDLE, start=1, illegal instr: illegal=1 in cycle T+1, stay in IDLE, flags and result unchanged.
- SELECT (T+1): busy=1. Drive adder_b = captured B; adder_c = 8'h01 for INC, else captured C. Load settle counter with SETTLE_CYCLES.
- SETTLE (T+2 .. T+1+SETTLE_CYCLES): adder operands held stable; counter decrements; exit when counter reaches 1.
- LATCH (T+2+SETTLE_CYCLES): compute the result. At the end of this cycle, register result and flags, assert we_a or we_d and done, and return to IDLE.
- Output cycle (T+3+SETTLE_CYCLES, i.e. T+7 by default, an 8-cycle op): done=1, we_x=1, busy=0.
  - A new start is accepted in this same cycle.
  - result and flags hold until the next completed op.
- Adder operand outputs:
  - Hold the captured values from SELECT through LATCH.
  - Hold their last value while IDLE.
- Functions:
  - 000 ADD: adder_sum, carry=adder_carry.
  - 001 INC: adder_sum with B+1, carry=adder_carry.
  - 010 AND: B&C.
  - 011 OR: B|C.
  - 100 XOR: B^C.
  - 101 NOT: ~B.
  - 110 SHL: circular, {B[6:0],B[7]}.
  - 111 CLR: 8'h00.
- Flags:
  - For logic/shift/clear ops, carry = 0.
  - zero = (result==8'h00).
  - sign = result[7].
  - All three update only on the output cycle.
- start is ignored while busy; instr, b_in and c_in changes are ignored after capture.
- Arithmetic is mod 256; the carry-out is taken only from the adder unit.

Test Plan:
- ADD, r=0, B=8'h00, C=8'h01, start at T: at T+7, result=8'h01, carry=0, zero=0, sign=0, we_a=1, done=1; busy=1 from T+1 to T+6.
- ADD, r=1, B=8'hFF, C=8'h01: result=8'h00, carry=1, zero=1, we_d=1 only; adder_b=FF and adder_c=01 held from T+1 to T+6.
- INC, B=8'h7F, C=8'h55: adder_c=8'h01, result=8'h80, sign=1, carry=0. Then SHL, B=8'h81: result=8'h03, carry=0.
- start pulsed at T+3 with a different instr while busy: ignored, original result and timing unchanged. Back-to-back start in the done cycle: second op done exactly 7 cycles later.
- instr=8'h90 with start: illegal=1 for one cycle, busy stays 0, no we strobes, flags unchanged.
- reset asserted at T+4 of an ADD: next cycle IDLE, all outputs 0, no done/we. A following op runs with full latency.
